// File: rtl/meter_scheduler_if.sv
// Meter-side bus between the scheduler (master) and the voltage/current meter (slave).
interface meter_scheduler_if;
  logic        start;
  logic        busy;
  logic [11:0] data_v;
  logic [11:0] data_i;

  modport master (output start, input busy, input data_v, input data_i);
  modport slave  (input start, output busy, output data_v, output data_i);
endinterface

// File: rtl/meter_scheduler.sv
// Schedules periodic and host-requested meter conversions, captures V/I results,
// and maintains watchdog, over-current and overrun sticky flags.
module meter_scheduler #(
  parameter int PERIOD_W       = 24,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ARM_WAIT       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period_cfg,
  input  logic                host_req,
  output logic                host_pending,
  input  logic [11:0]         i_limit,
  input  logic                ovc_clear,
  input  logic                err_clear,
  meter_scheduler_if.master   meter,
  output logic [11:0]         sample_v,
  output logic [11:0]         sample_i,
  output logic                sample_valid,
  output logic                sample_src,
  output logic                ovc_trip,
  output logic                timeout_err,
  output logic                overrun,
  output logic                sched_busy
);

  localparam int WD_MAX = (TIMEOUT_CYCLES > ARM_WAIT) ? TIMEOUT_CYCLES : ARM_WAIT;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam logic [WD_W-1:0] TO_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] ARM_LAST = WD_W'(ARM_WAIT - 1);

  typedef enum logic [2:0] {IDLE, START, ARM, RUN, CAPTURE} state_t;

  state_t              state, state_n;
  logic                abort;
  logic                capture;
  logic                src;
  logic                pend_host, pend_per;
  logic [WD_W-1:0]     wdog;
  logic [PERIOD_W-1:0] per_cnt, per_eff;
  logic                tmr_run, expire;
  logic                sel_clear, clr_host, clr_per;

  // NOTE: state and all datapath registers use non-blocking assignments so every
  // always_ff block sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_n = state;
    abort   = 1'b0;
    case (state)
      IDLE:    if (pend_host || pend_per) state_n = START;
      START:   state_n = ARM;
      ARM: begin
        if (meter.busy) state_n = RUN;
        else if (wdog == ARM_LAST) begin
          state_n = IDLE;
          abort   = 1'b1;
        end
      end
      RUN: begin
        if (!meter.busy) state_n = CAPTURE;
        else if (wdog == TO_LAST) begin
          state_n = IDLE;
          abort   = 1'b1;
        end
      end
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    meter.start  = (state == START);
    sched_busy   = (state != IDLE);
    capture      = (state == CAPTURE);
    host_pending = pend_host;
    sel_clear    = capture || abort;
    clr_host     = sel_clear && src;
    clr_per      = sel_clear && !src;
  end

  // A zero count means "not yet loaded"; it behaves exactly like a fresh load of
  // period_cfg, so reset needs no dependence on the period_cfg input.
  always_comb begin
    tmr_run = enable && (period_cfg != '0);
    per_eff = (per_cnt == '0) ? period_cfg : per_cnt;
    expire  = tmr_run && (per_eff <= PERIOD_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt   <= '0;
      pend_per  <= 1'b0;
      pend_host <= 1'b0;
      src       <= 1'b0;
      wdog      <= '0;
    end else begin
      if (!tmr_run)    per_cnt <= '0;
      else if (expire) per_cnt <= period_cfg;
      else             per_cnt <= per_eff - PERIOD_W'(1);

      if (!enable)      pend_per <= 1'b0;
      else if (expire)  pend_per <= 1'b1;
      else if (clr_per) pend_per <= 1'b0;

      if (host_req)      pend_host <= 1'b1;
      else if (clr_host) pend_host <= 1'b0;

      if (state == IDLE && state_n == START) src <= pend_host;

      case (state)
        START:   wdog <= '0;
        ARM:     wdog <= meter.busy ? '0 : wdog + WD_W'(1);
        RUN:     wdog <= wdog + WD_W'(1);
        default: wdog <= wdog;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_v     <= '0;
      sample_i     <= '0;
      sample_src   <= 1'b0;
      sample_valid <= 1'b0;
      ovc_trip     <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= capture;
      if (capture) begin
        sample_v   <= meter.data_v;
        sample_i   <= meter.data_i;
        sample_src <= src;
      end

      if (capture && (meter.data_i > i_limit)) ovc_trip <= 1'b1;
      else if (ovc_clear)                       ovc_trip <= 1'b0;

      if (abort)          timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;

      if (expire && pend_per && !clr_per) overrun <= 1'b1;
      else if (err_clear)                 overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_meter_scheduler.sv
// Directed bench for meter_scheduler with a behavioural meter model driven on the falling edge.
module tb_meter_scheduler;

  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable = 1'b0;
  logic [PW-1:0] period_cfg = '0;
  logic          host_req = 1'b0;
  logic [11:0]   i_limit = 12'hFFF;
  logic          ovc_clear = 1'b0;
  logic          err_clear = 1'b0;
  logic          host_pending, sample_valid, sample_src;
  logic          ovc_trip, timeout_err, overrun, sched_busy;
  logic [11:0]   sample_v, sample_i;

  meter_scheduler_if mif ();

  meter_scheduler #(.PERIOD_W(PW), .TIMEOUT_CYCLES(1000), .ARM_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period_cfg   (period_cfg),
    .host_req     (host_req),
    .host_pending (host_pending),
    .i_limit      (i_limit),
    .ovc_clear    (ovc_clear),
    .err_clear    (err_clear),
    .meter        (mif.master),
    .sample_v     (sample_v),
    .sample_i     (sample_i),
    .sample_valid (sample_valid),
    .sample_src   (sample_src),
    .ovc_trip     (ovc_trip),
    .timeout_err  (timeout_err),
    .overrun      (overrun),
    .sched_busy   (sched_busy)
  );

  always #5 clk = ~clk;

  // Cycle index: bumped on each rising edge, read on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Meter model: mode 0 normal, 1 never raises busy, 2 busy stuck high.
  int busy_len = 50;
  int mode = 0;
  int mcnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {host_pending, mif.start, sample_valid, sample_src, ovc_trip,
            timeout_err, overrun, sched_busy, sample_v, sample_i};
  endfunction

  task automatic wait_start(input string tag, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mif.start) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_start_timeout"}, mif.start, 1'b1);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sample_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_valid_timeout"}, sample_valid, 1'b1);
  endtask

  task automatic pulse_host();
    host_req = 1'b1;
    @(negedge clk);
    host_req = 1'b0;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  initial begin
    mif.busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mif.busy = 1'b0;
        mcnt     = 0;
      end else if (mif.start && mode != 1) begin
        mif.busy = 1'b1;
        mcnt     = busy_len;
      end else if (mif.busy && mode != 2) begin
        mcnt--;
        if (mcnt == 0) mif.busy = 1'b0;
      end
    end
  end

  initial begin
    int t0, t1, t2, tv, tv2, c, r;
    logic saw_valid;

    rst = 1'b1;
    mif.data_v = 12'h7A0;
    mif.data_i = 12'h100;
    period_cfg = 100;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", all_outputs(), 32'h0);

    // Periodic service, period 100, busy 50 cycles.
    rst = 1'b0;
    enable = 1'b1;
    wait_start("p1a", 150, t0);
    wait_valid("p1a", 100, tv);
    check("p1_valid_latency", tv - t0, 52);
    check("p1_sample_v", sample_v, 12'h7A0);
    check("p1_sample_i", sample_i, 12'h100);
    check("p1_sample_src", sample_src, 1'b0);
    check("p1_flags", {ovc_trip, timeout_err, overrun}, 3'b000);
    @(negedge clk);
    check("p1_valid_one_cycle", sample_valid, 1'b0);
    wait_start("p1b", 100, t1);
    check("p1_period", t1 - t0, 100);
    wait_valid("p1b", 100, tv);
    wait_start("p1c", 100, t2);
    check("p1_period_again", t2 - t1, 100);
    wait_valid("p1c", 100, tv);

    // Host request in the cycle of the next expiry (expiry edge ends cycle t2+98).
    busy_len = 20;
    while (cyc < t2 + 98) @(negedge clk);
    pulse_host();
    check("p2_host_pending", host_pending, 1'b1);
    wait_valid("p2_host", 60, tv);
    check("p2_first_src_host", sample_src, 1'b1);
    wait_valid("p2_per", 60, tv2);
    check("p2_second_src_per", sample_src, 1'b0);
    check("p2_back_to_back", tv2 - tv, 23);
    check("p2_no_overrun", overrun, 1'b0);
    check("p2_host_pending_clear", host_pending, 1'b0);

    // Overrun: period 10 with a 40-cycle conversion.
    enable = 1'b0;
    period_cfg = 10;
    busy_len = 40;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    c = cyc;
    while (cyc < c + 19) @(negedge clk);
    check("p3_overrun_before", overrun, 1'b0);
    @(negedge clk);
    check("p3_overrun_set", overrun, 1'b1);
    enable = 1'b0;
    wait_valid("p3", 60, tv);
    check("p3_completes_after_disable", sample_src, 1'b0);
    repeat (10) @(negedge clk);
    check("p3_no_restart", sched_busy, 1'b0);
    check("p3_overrun_held", overrun, 1'b1);
    pulse_err_clear();
    check("p3_overrun_cleared", overrun, 1'b0);

    // Over-current comparator boundary.
    busy_len = 10;
    i_limit = 12'h200;
    mif.data_i = 12'h201;
    pulse_host();
    wait_valid("p4_trip", 40, tv);
    check("p4_ovc_at_valid", ovc_trip, 1'b1);
    check("p4_sample_i", sample_i, 12'h201);
    repeat (5) @(negedge clk);
    check("p4_ovc_held", ovc_trip, 1'b1);
    ovc_clear = 1'b1;
    @(negedge clk);
    ovc_clear = 1'b0;
    check("p4_ovc_cleared", ovc_trip, 1'b0);
    mif.data_i = 12'h200;
    pulse_host();
    wait_valid("p4_equal", 40, tv);
    check("p4_equal_no_trip", ovc_trip, 1'b0);
    check("p4_sample_i_equal", sample_i, 12'h200);

    // Meter never raises busy: abort after ARM_WAIT cycles.
    mode = 1;
    pulse_host();
    wait_start("p5", 20, t0);
    saw_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      saw_valid |= sample_valid;
      if (k == 4) check("p5_timeout_before", timeout_err, 1'b0);
      if (k == 5) check("p5_timeout_set", timeout_err, 1'b1);
    end
    check("p5_no_sample", saw_valid, 1'b0);
    check("p5_host_pending_clear", host_pending, 1'b0);
    pulse_err_clear();
    check("p5_timeout_cleared", timeout_err, 1'b0);

    // Busy stuck high: watchdog fires after 1000 RUN cycles.
    mode = 2;
    busy_len = 50;
    pulse_host();
    wait_start("p6", 20, t0);
    while (cyc < t0 + 1001) @(negedge clk);
    check("p6_timeout_before", timeout_err, 1'b0);
    check("p6_pending_before", host_pending, 1'b1);
    @(negedge clk);
    check("p6_timeout_set", timeout_err, 1'b1);
    check("p6_pending_cleared", host_pending, 1'b0);
    mode = 0;
    repeat (60) @(negedge clk);
    pulse_err_clear();

    // Reset during RUN, then periodic restart with period 20.
    pulse_host();
    wait_start("p7", 20, t0);
    repeat (10) @(negedge clk);
    check("p7_running", sched_busy, 1'b1);
    rst = 1'b1;
    #1 check("p7_reset_outputs", all_outputs(), 32'h0);
    period_cfg = 20;
    enable = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    // Expiry on the 20th edge after release, START on the next.
    wait_start("p7_restart", 40, t1);
    check("p7_first_start", t1 - r, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
